// File: rtl/systolic_pkg.sv
// Shared defaults, result-width derivation and controller state encoding
// for the weight-stationary systolic matrix multiplier.
package systolic_pkg;

  localparam int DEF_N  = 3;
  localparam int DEF_DW = 8;

  // Wide enough for N full-precision products summed without overflow
  function automatic int calc_aw(input int n, input int dw);
    return 2 * dw + $clog2(n);
  endfunction

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/systolic_mm_if.sv
// Request/result bundle of systolic_mm: operands and mode in, status and
// result matrix out.
interface systolic_mm_if import systolic_pkg::*; #(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = calc_aw(N, DW)
) ();

  logic              start;
  logic              sgn;
  logic [N*N*DW-1:0] a_in;
  logic [N*N*DW-1:0] w_in;
  logic              busy;
  logic              done;
  logic [N*N*AW-1:0] c_out;

  modport master (
    output start, sgn, a_in, w_in,
    input  busy, done, c_out
  );

  modport slave (
    input  start, sgn, a_in, w_in,
    output busy, done, c_out
  );

endinterface

// File: rtl/systolic_mm_mac_pe.sv
// One processing element: activation moves right one column per cycle,
// partial sum moves down with this PE's product added.
module mac_pe import systolic_pkg::*; #(
  parameter int DW = DEF_DW,
  parameter int AW = calc_aw(DEF_N, DEF_DW)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          sgn,
  input  logic [DW-1:0] act_in,
  input  logic [DW-1:0] weight,
  input  logic [AW-1:0] mac_in,
  output logic [DW-1:0] act_out,
  output logic [AW-1:0] mac_out
);

  logic signed [DW:0]     act_x_s;
  logic signed [DW:0]     wgt_x_s;
  logic signed [2*DW+1:0] prod_s;
  logic        [AW-1:0]   prod_ext_s;
  logic        [DW-1:0]   act_r;
  logic        [AW-1:0]   mac_r;

  // One extra bit lets a single signed multiplier serve both operand modes
  assign act_x_s    = signed'({sgn & act_in[DW-1], act_in});
  assign wgt_x_s    = signed'({sgn & weight[DW-1], weight});
  assign prod_s     = act_x_s * wgt_x_s;
  assign prod_ext_s = AW'(prod_s);

  // Activation pass-through and partial-sum update
  always_ff @(posedge clk) begin
    if (clr) begin
      act_r <= {DW{1'b0}};
      mac_r <= {AW{1'b0}};
    end else begin
      act_r <= act_in;
      mac_r <= mac_in + prod_ext_s;
    end
  end

  assign act_out = act_r;
  assign mac_out = mac_r;

endmodule

// File: rtl/systolic_mm.sv
// N x N weight-stationary systolic multiplier: C = A * W with skewed
// activation injection, column-wise result capture and a single done pulse.
module systolic_mm import systolic_pkg::*; #(
  parameter int N  = DEF_N,
  parameter int DW = DEF_DW,
  parameter int AW = calc_aw(N, DW)
) (
  input  logic          clk,
  input  logic          nrst,
  systolic_mm_if.slave  bus
);

  localparam int CW = $clog2(3 * N + 1);

  state_t            state_r;
  state_t            state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic              accept_s;
  logic              feed_s;
  logic              run_s;
  logic              pe_clr_s;
  logic              sgn_r;
  logic [N*N*DW-1:0] a_r;
  logic [N*N*DW-1:0] w_r;
  logic [DW-1:0]     a_s    [N][N];
  logic [DW-1:0]     w_s    [N][N];
  logic [DW-1:0]     inj_s  [N];
  logic [DW-1:0]     act_s  [N][N];
  logic [AW-1:0]     psum_s [N][N];
  logic [AW-1:0]     cap_r  [N][N];
  logic [N*N*AW-1:0] cap_flat_s;
  logic [N*N*AW-1:0] c_out_r;
  logic              busy_r;
  logic              done_r;

  assign accept_s = (state_r == IDLE) && bus.start;
  assign feed_s   = (state_r == FEED);
  assign run_s    = (state_r == FEED) || (state_r == DRAIN);
  // Clearing the array at accept keeps consecutive operations independent
  assign pe_clr_s = !nrst || accept_s;

  // Controller state register
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state: cnt_r numbers the FEED and DRAIN steps consecutively
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = bus.start ? FEED : IDLE;
      FEED:    state_nxt_s = (cnt_r == CW'(2 * N - 2)) ? DRAIN : FEED;
      DRAIN:   state_nxt_s = (cnt_r == CW'(3 * N - 1)) ? DONE : DRAIN;
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Step counter across FEED and DRAIN
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_r <= {CW{1'b0}};
    end else if (run_s) begin
      cnt_r <= cnt_r + CW'(1);
    end else begin
      cnt_r <= {CW{1'b0}};
    end
  end

  // Operand capture so later input changes cannot disturb a running op
  always_ff @(posedge clk) begin
    if (!nrst) begin
      a_r   <= {(N*N*DW){1'b0}};
      w_r   <= {(N*N*DW){1'b0}};
      sgn_r <= 1'b0;
    end else if (accept_s) begin
      a_r   <= bus.a_in;
      w_r   <= bus.w_in;
      sgn_r <= bus.sgn;
    end else begin
      a_r   <= a_r;
      w_r   <= w_r;
      sgn_r <= sgn_r;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_unpack_r
    for (genvar c = 0; c < N; c++) begin : g_unpack_c
      assign a_s[r][c] = a_r[(r*N+c)*DW +: DW];
      assign w_s[r][c] = w_r[(r*N+c)*DW +: DW];
      assign cap_flat_s[(r*N+c)*AW +: AW] = cap_r[r][c];
    end
  end

  // Row k receives A[i][k] at step i+k; zero everywhere else
  always_comb begin
    for (int k = 0; k < N; k++) begin
      inj_s[k] = {DW{1'b0}};
      for (int i = 0; i < N; i++) begin
        inj_s[k] = inj_s[k] |
                   ((feed_s && (cnt_r == CW'(i + k))) ? a_s[i][k] : {DW{1'b0}});
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_row
    logic unused_act_s;
    assign unused_act_s = ^act_s[k][N-1];

    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] act_in_s;
      logic [AW-1:0] mac_in_s;

      if (j == 0) begin : g_act_edge
        assign act_in_s = inj_s[k];
      end else begin : g_act_inner
        assign act_in_s = act_s[k][j-1];
      end

      if (k == 0) begin : g_sum_edge
        assign mac_in_s = {AW{1'b0}};
      end else begin : g_sum_inner
        assign mac_in_s = psum_s[k-1][j];
      end

      mac_pe #(.DW(DW), .AW(AW)) u_pe (
        .clk     (clk),
        .clr     (pe_clr_s),
        .sgn     (sgn_r),
        .act_in  (act_in_s),
        .weight  (w_s[k][j]),
        .mac_in  (mac_in_s),
        .act_out (act_s[k][j]),
        .mac_out (psum_s[k][j])
      );
    end
  end

  // C[i][j] leaves the bottom row of column j at step N+i+j
  always_ff @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (!nrst) begin
          cap_r[i][j] <= {AW{1'b0}};
        end else if (run_s && (cnt_r == CW'(N + i + j))) begin
          cap_r[i][j] <= psum_s[N-1][j];
        end else begin
          cap_r[i][j] <= cap_r[i][j];
        end
      end
    end
  end

  // Registered status and result, all published together on entering DONE
  always_ff @(posedge clk) begin
    if (!nrst) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      c_out_r <= {(N*N*AW){1'b0}};
    end else begin
      busy_r  <= (state_nxt_s != IDLE);
      done_r  <= (state_nxt_s == DONE);
      if ((state_r == DRAIN) && (state_nxt_s == DONE)) begin
        c_out_r <= cap_flat_s;
      end else begin
        c_out_r <= c_out_r;
      end
    end
  end

  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.c_out = c_out_r;

endmodule
